// File: rtl/seg_pkg.sv
// Shared types and constants for the shape splitter.
// Shape/kind/state encodings, primitive counts, default widths.
package seg_pkg;

    localparam int X_W_DEF     = 10;
    localparam int Y_W_DEF     = 9;
    localparam int COLOR_W_DEF = 16;

    typedef enum logic [1:0] {
        LINE   = 2'b00,
        CIRCLE = 2'b01,
        TRI    = 2'b10,
        SQUARE = 2'b11
    } shape_t;

    typedef enum logic {
        KIND_SEG    = 1'b0,
        KIND_CIRCLE = 1'b1
    } kind_t;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [2:0] LINE_CNT   = 3'd1;
    localparam logic [2:0] CIRCLE_CNT = 3'd1;
    localparam logic [2:0] TRI_CNT    = 3'd3;
    localparam logic [2:0] SQUARE_CNT = 3'd4;

    // Index of the final primitive of a shape.
    function automatic logic [1:0] last_idx(shape_t s);
        logic [2:0] n;
        n = LINE_CNT;
        unique case (s)
            LINE:   n = LINE_CNT;
            CIRCLE: n = CIRCLE_CNT;
            TRI:    n = TRI_CNT;
            SQUARE: n = SQUARE_CNT;
        endcase
        n = n - 3'd1;
        return n[1:0];
    endfunction

endpackage

// File: rtl/seg_table.sv
// Combinational decomposition of a shape into two-point primitives.
// In: shape, idx, pts {P2,P1,P0}. Out: seg {start,end}, kind, last.
module seg_table
    import seg_pkg::*;
#(
    parameter int X_W = X_W_DEF,
    parameter int Y_W = Y_W_DEF,
    localparam int PT_W = X_W + Y_W
) (
    input  shape_t              shape,
    input  logic [1:0]          idx,
    input  logic [3*PT_W-1:0]   pts,
    output logic [2*PT_W-1:0]   seg,
    output kind_t               kind,
    output logic                last
);

    logic [PT_W-1:0] p0;
    logic [PT_W-1:0] p1;
    logic [PT_W-1:0] p2;
    logic [PT_W-1:0] pb;
    logic [PT_W-1:0] pd;

    assign p0 = pts[0*PT_W +: PT_W];
    assign p1 = pts[1*PT_W +: PT_W];
    assign p2 = pts[2*PT_W +: PT_W];

    // Remaining square corners: B=(x1,y0), D=(x0,y1).
    assign pb = {p1[PT_W-1 -: X_W], p0[Y_W-1:0]};
    assign pd = {p0[PT_W-1 -: X_W], p1[Y_W-1:0]};

    always_comb begin
        seg  = {p0, p1};
        kind = KIND_SEG;
        unique case (shape)
            LINE: begin
                seg = {p0, p1};
            end
            CIRCLE: begin
                kind = KIND_CIRCLE;
            end
            TRI: begin
                unique case (idx)
                    2'd1:    seg = {p1, p2};
                    2'd2:    seg = {p2, p0};
                    default: seg = {p0, p1};
                endcase
            end
            SQUARE: begin
                unique case (idx)
                    2'd0: seg = {p0, pb};
                    2'd1: seg = {pb, p1};
                    2'd2: seg = {p1, pd};
                    2'd3: seg = {pd, p0};
                endcase
            end
        endcase
    end

    assign last = (idx == last_idx(shape));

endmodule

// File: rtl/seg_splitter.sv
// Splits a shape descriptor into a stream of registered primitives.
// In: descriptor over in_valid/in_ready, flush. Out: primitive stream.
module seg_splitter
    import seg_pkg::*;
#(
    parameter int X_W     = X_W_DEF,
    parameter int Y_W     = Y_W_DEF,
    parameter int COLOR_W = COLOR_W_DEF,
    localparam int PT_W   = X_W + Y_W
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_shape,
    input  logic [3*PT_W-1:0]   in_pts,
    input  logic [COLOR_W-1:0]  in_color,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*PT_W-1:0]   out_seg,
    output logic                out_kind,
    output logic [COLOR_W-1:0]  out_color,
    output logic                out_last
);

    state_t            state_q;
    state_t            state_d;
    logic [1:0]        idx_q;
    logic [1:0]        idx_d;
    shape_t            shape_q;
    logic [3*PT_W-1:0] pts_q;

    logic              valid_d;
    logic              last_d;
    logic              load;
    logic              hs;
    logic              accept;
    logic              advance;

    shape_t            tbl_shape;
    logic [1:0]        tbl_idx;
    logic [3*PT_W-1:0] tbl_pts;
    logic [2*PT_W-1:0] tbl_seg;
    kind_t             tbl_kind;
    logic              tbl_last;

    assign hs       = out_valid && out_ready;
    assign in_ready = !flush && (state_q == IDLE || (hs && out_last));
    assign accept   = in_valid && in_ready;
    assign advance  = hs && !out_last && !flush;

    // The table looks one primitive ahead so outputs can be registered:
    // either primitive 0 of the incoming shape or idx+1 of the current one.
    assign tbl_shape = accept ? shape_t'(in_shape) : shape_q;
    assign tbl_idx   = accept ? 2'd0 : idx_q + 2'd1;
    assign tbl_pts   = accept ? in_pts : pts_q;

    seg_table #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_table (
        .shape (tbl_shape),
        .idx   (tbl_idx),
        .pts   (tbl_pts),
        .seg   (tbl_seg),
        .kind  (tbl_kind),
        .last  (tbl_last)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = out_valid;
        last_d  = out_last;
        load    = 1'b0;
        if (flush) begin
            state_d = IDLE;
            idx_d   = 2'd0;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else if (accept) begin
            state_d = EMIT;
            idx_d   = 2'd0;
            valid_d = 1'b1;
            last_d  = tbl_last;
            load    = 1'b1;
        end else if (advance) begin
            idx_d   = tbl_idx;
            last_d  = tbl_last;
            load    = 1'b1;
        end else if (hs) begin
            state_d = IDLE;
            idx_d   = 2'd0;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            idx_q     <= 2'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            out_valid <= valid_d;
            out_last  <= last_d;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shape_q   <= LINE;
            pts_q     <= '0;
            out_color <= '0;
        end else if (accept) begin
            shape_q   <= shape_t'(in_shape);
            pts_q     <= in_pts;
            out_color <= in_color;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_seg  <= '0;
            out_kind <= 1'b0;
        end else if (load) begin
            out_seg  <= tbl_seg;
            out_kind <= tbl_kind;
        end
    end

endmodule

// File: tb/tb_seg_splitter.sv
// Self-checking bench for seg_splitter.
// Queue-based reference model plus directed literal checks.
module tb_seg_splitter;

    localparam int PT_W = 19;

    typedef struct packed {
        logic [2*PT_W-1:0] seg;
        logic              kind;
        logic [15:0]       color;
        logic              last;
    } prim_t;

    logic              clk;
    logic              n_rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_shape;
    logic [3*PT_W-1:0] in_pts;
    logic [15:0]       in_color;
    logic              out_valid;
    logic              out_ready;
    logic [2*PT_W-1:0] out_seg;
    logic              out_kind;
    logic [15:0]       out_color;
    logic              out_last;

    int npass = 0;
    int ntotal = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int hs_cnt = 0;
    int run = 0;
    int last_run = 0;

    prim_t q[$];
    logic [2*PT_W-1:0] sq_exp[4];

    seg_splitter dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_shape  (in_shape),
        .in_pts    (in_pts),
        .in_color  (in_color),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_seg   (out_seg),
        .out_kind  (out_kind),
        .out_color (out_color),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        ntotal++;
        if (got === exp) npass++;
        else $display("FAIL %s got=%0h want=%0h", name, got, exp);
    endtask

    function automatic logic [PT_W-1:0] pt(input int x, input int y);
        logic [9:0] xv;
        logic [8:0] yv;
        xv = x[9:0];
        yv = y[8:0];
        return {xv, yv};
    endfunction

    // Reference: list the shape's vertices, then join them in a ring.
    task automatic model_push(input logic [1:0] s,
                              input logic [3*PT_W-1:0] p,
                              input logic [15:0] c);
        logic [PT_W-1:0] v[4];
        logic [PT_W-1:0] a;
        logic [PT_W-1:0] b;
        prim_t e;
        int n;
        a = p[0 +: PT_W];
        b = p[PT_W +: PT_W];
        v[0] = a;
        v[1] = b;
        v[2] = p[2*PT_W +: PT_W];
        v[3] = '0;
        n = 1;
        if (s == 2'd2) n = 3;
        if (s == 2'd3) begin
            n = 4;
            v[0] = a;
            v[1] = {b[18:9], a[8:0]};
            v[2] = b;
            v[3] = {a[18:9], b[8:0]};
        end
        for (int i = 0; i < n; i++) begin
            e.seg   = (n == 1) ? {a, b} : {v[i], v[(i + 1) % n]};
            e.kind  = (s == 2'd1);
            e.color = c;
            e.last  = (i == n - 1);
            q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (!n_rst) begin
            q.delete();
            run = 0;
        end else begin
            chk("m_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("m_in_ready", 64'(in_ready),
                64'(!flush && (q.size() == 0 ||
                    (out_ready && q[0].last))));
            if (q.size() > 0) begin
                chk("m_seg", 64'(out_seg), 64'(q[0].seg));
                chk("m_kind", 64'(out_kind), 64'(q[0].kind));
                chk("m_color", 64'(out_color), 64'(q[0].color));
                chk("m_last", 64'(out_last), 64'(q[0].last));
            end
            if (out_valid) run++;
            else begin
                if (run > 0) last_run = run;
                run = 0;
            end
            if (flush) q.delete();
            else begin
                if (out_valid && out_ready && q.size() > 0) begin
                    void'(q.pop_front());
                    hs_cnt++;
                end
                if (in_valid && in_ready)
                    model_push(in_shape, in_pts, in_color);
            end
        end
    end

    task automatic send(input logic [1:0] s,
                        input logic [3*PT_W-1:0] p,
                        input logic [15:0] c);
        int n;
        in_shape = s;
        in_pts   = p;
        in_color = c;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                ntotal++;
                $display("FAIL accept_timeout got=%0d want=accept", n);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc_cyc  = cyc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        int h0;
        int t0;
        logic [7:0] pat;
        sq_exp[0] = {10'd5, 9'd5, 10'd50, 9'd5};
        sq_exp[1] = {10'd50, 9'd5, 10'd50, 9'd40};
        sq_exp[2] = {10'd50, 9'd40, 10'd5, 9'd40};
        sq_exp[3] = {10'd5, 9'd40, 10'd5, 9'd5};

        n_rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_shape = 2'd0;
        in_pts = '0;
        in_color = '0;
        out_ready = 1'b1;
        #12;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_seg", 64'(out_seg), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        #11;
        n_rst = 1'b1;
        tick();

        // Line
        send(2'd0, {pt(0, 0), pt(100, 200), pt(10, 20)}, 16'h1111);
        chk("line_valid", 64'(out_valid), 64'd1);
        chk("line_seg", 64'(out_seg),
            64'({10'd10, 9'd20, 10'd100, 9'd200}));
        chk("line_kind", 64'(out_kind), 64'd0);
        chk("line_last", 64'(out_last), 64'd1);
        tick();
        chk("line_done", 64'(out_valid), 64'd0);

        // Square
        send(2'd3, {pt(0, 0), pt(50, 40), pt(5, 5)}, 16'h2222);
        for (int i = 0; i < 4; i++) begin
            chk("sq_seg", 64'(out_seg), 64'(sq_exp[i]));
            chk("sq_last", 64'(out_last), 64'(i == 3));
            tick();
        end
        chk("sq_done", 64'(out_valid), 64'd0);

        // Triangle with stalls
        out_ready = 1'b0;
        h0 = hs_cnt;
        send(2'd2, {pt(4, 6), pt(8, 0), pt(0, 0)}, 16'h3333);
        chk("tri_p0", 64'(out_seg), 64'({10'd0, 9'd0, 10'd8, 9'd0}));
        pat = 8'b1110_1001;
        for (int i = 0; i < 8; i++) begin
            out_ready = pat[i];
            tick();
        end
        out_ready = 1'b1;
        repeat (3) tick();
        chk("tri_count", 64'(hs_cnt - h0), 64'd3);

        // Square then circle back to back
        send(2'd3, {pt(0, 0), pt(50, 40), pt(5, 5)}, 16'h4444);
        t0 = acc_cyc;
        send(2'd1, {pt(0, 0), pt(30, 0), pt(320, 240)}, 16'h5555);
        chk("b2b_gap", 64'(acc_cyc - t0), 64'd4);
        chk("circ_valid", 64'(out_valid), 64'd1);
        chk("circ_kind", 64'(out_kind), 64'd1);
        chk("circ_seg", 64'(out_seg),
            64'({10'd320, 9'd240, 10'd30, 9'd0}));
        chk("circ_color", 64'(out_color), 64'h5555);
        repeat (3) tick();

        // Square + triangle run length
        last_run = 0;
        send(2'd3, {pt(0, 0), pt(9, 9), pt(1, 1)}, 16'h6666);
        send(2'd2, {pt(7, 3), pt(2, 8), pt(1, 1)}, 16'h7777);
        repeat (10) tick();
        chk("sq_tri_run", 64'(last_run), 64'd7);

        // Flush at square idx 1
        send(2'd3, {pt(0, 0), pt(50, 40), pt(5, 5)}, 16'h8888);
        tick();
        chk("fl_idx1", 64'(out_seg), 64'(sq_exp[1]));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_last", 64'(out_last), 64'd0);
        send(2'd0, {pt(0, 0), pt(3, 4), pt(1, 2)}, 16'h9999);
        chk("fl_line", 64'(out_seg), 64'({10'd1, 9'd2, 10'd3, 9'd4}));
        chk("fl_line_last", 64'(out_last), 64'd1);
        repeat (2) tick();

        // Reset during triangle
        out_ready = 1'b0;
        send(2'd2, {pt(4, 6), pt(8, 0), pt(0, 0)}, 16'hAAAA);
        #3;
        n_rst = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_seg", 64'(out_seg), 64'd0);
        chk("ar_kind", 64'(out_kind), 64'd0);
        chk("ar_color", 64'(out_color), 64'd0);
        chk("ar_last", 64'(out_last), 64'd0);
        chk("ar_in_ready", 64'(in_ready), 64'd1);
        #8;
        n_rst = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("ar_ready_after", 64'(in_ready), 64'd1);
        send(2'd0, {pt(0, 0), pt(7, 8), pt(5, 6)}, 16'hBBBB);
        chk("ar_line", 64'(out_seg), 64'({10'd5, 9'd6, 10'd7, 9'd8}));
        chk("ar_line_color", 64'(out_color), 64'hBBBB);
        repeat (3) tick();
        chk("model_drained", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/seg_splitter.md
# seg_splitter

Parametrised subshape splitter for the 2D GPU shape pipeline. Accepts one shape descriptor (line, circle, triangle or axis-aligned square) over a valid/ready handshake. Emits it as a stream of two-point primitives, one per output handshake, toward the line and circle rasterisers. Adds over the previous splitter: configurable coordinate/colour widths, real triangle and square decomposition, backpressure, last-segment marking, back-to-back shapes and flush.

## Interface
- X_W, 10, x coordinate width
- Y_W, 9, y coordinate width; PT_W = X_W+Y_W, point = {x, y}, x in upper bits
- COLOR_W, 16, colour width
- clk  in  1  clock, all logic on rising edge
- n_rst  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous abort of the shape in progress
- in_valid  in  1  descriptor valid
- in_ready  out  1  descriptor accepted when in_valid && in_ready
- in_shape  in  2  00 line, 01 circle, 10 triangle, 11 square
- in_pts  in  3*PT_W  point k at [k*PT_W +: PT_W] (P0, P1, P2)
- in_color  in  COLOR_W  shape colour
- out_valid  out  1  primitive valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_seg  out  2*PT_W  {start point, end point}
- out_kind  out  1  0 line segment, 1 circle (start = centre, end.x = radius)
- out_color  out  COLOR_W  colour of captured shape
- out_last  out  1  final primitive of the shape

## Operation
- FSM states: IDLE, EMIT. State, segment index idx (2 bits) and captured shape/points/colour are registers.
- in_ready = !flush && (state==IDLE || (out_valid && out_ready && out_last)).
- On accept: capture shape, pts and colour. idx=0, state=EMIT, out_valid=1 next cycle carrying primitive 0.
- In EMIT, on out handshake:
  - not last: idx+1, next primitive presented next cycle.
  - last: with no new accept, state=IDLE and out_valid=0.
  - last with a new accept in the same cycle: stays EMIT and presents primitive 0 of the new shape.
- While out_valid && !out_ready: out_seg, out_kind, out_color, out_last held stable.
- Decomposition, with A=P0=(x0,y0), C=P1=(x1,y1), B=(x1,y0), D=(x0,y1):
  - line: (P0,P1); 1 primitive, kind 0
  - circle: (P0,P1) unchanged; 1 primitive, kind 1
  - triangle: (P0,P1),(P1,P2),(P2,P0); 3 primitives
  - square: (A,B),(B,C),(C,D),(D,A); 4 primitives
- out_last=1 exactly when idx = count-1. P2 is ignored for line, circle and square.
- Degenerate shapes (coincident points, zero radius) are emitted unchanged; no filtering or arithmetic on coordinates.
- flush: next cycle state=IDLE, out_valid=0, out_last=0. The in-flight shape is dropped even if out_ready=1 that cycle. flush blocks accept in the same cycle via in_ready.

## Timing
- Reset values: out_valid 0, out_seg 0, out_kind 0, out_color 0, out_last 0, state IDLE, idx 0. in_ready evaluates 1 while in reset; stimulus must not drive in_valid before n_rst release.
- Latency: accept at edge N gives out_valid=1 from edge N+1.
- Throughput with out_ready held 1: one primitive per cycle and no bubble between shapes. Square + triangle = 7 consecutive valid cycles.
- Reset assertion mid-shape returns to reset values immediately (asynchronous). The captured shape is lost.
- All outputs except in_ready are registered. in_ready is combinational from state, out_valid, out_ready, out_last and flush.

## Structure
- Package seg_pkg: shape_t enum (LINE, CIRCLE, TRI, SQUARE), kind_t enum (KIND_SEG, KIND_CIRCLE), localparam prim_count per shape, default X_W/Y_W/COLOR_W.
- Sub-module seg_table: combinational; inputs captured shape, idx and points; outputs segment, kind and last. Holds the decomposition rules. The top holds FSM, capture registers and handshake.

## Test plan
- Line P0=(10,20), P1=(100,200), out_ready=1 -> one primitive {(10,20),(100,200)}, kind 0, out_last=1, one cycle after accept.
- Square P0=(5,5), P1=(50,40) -> (5,5)-(50,5), (50,5)-(50,40), (50,40)-(5,40), (5,40)-(5,5) on 4 consecutive cycles; out_last only on the 4th.
- Triangle (0,0),(8,0),(4,6) with out_ready toggled 1,0,0,1,... -> 3 primitives in order, outputs stable during stalls, no loss or duplication.
- Square then circle (centre (320,240), radius 30) offered back-to-back -> circle accepted on the square's last handshake; circle primitive kind 1 on the next cycle, no gap.
- flush during square idx=1 -> out_valid 0 next cycle; following line accepted and emitted correctly with idx restarted at 0.
- n_rst pulsed during triangle emission -> all outputs at reset values immediately; in_ready=1 after release; next shape emitted normally.
